// File: rtl/mmio_input_port.sv
// mmio_input_port: memory-mapped, debounced switch/button reader with sticky button-edge flags and a switch-change counter
module mmio_input_port #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0100,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic [4:0]  btn,
  input  logic        ReadEnM,
  input  logic [31:0] ReadAddrM,
  output logic [31:0] ReadDataM,
  output logic        HitM
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int NI = 21;
  logic [SYNC_STAGES-1:0][NI-1:0] sync_q, sync_d;
  logic [NI-1:0]                  synced, stable_q, stable_d;
  logic [NI-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [4:0]                     btn_edge_q, btn_edge_d;
  logic [15:0]                    sw_changes_q, sw_changes_d;
  logic                           edge_rd;
  logic                           unused;
  assign unused = ^ReadAddrM[1:0];
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn, sw};
    synced = sync_q[SYNC_STAGES-1];
    stable_d = stable_q;
    cnt_d = '0;
    for (int i = 0; i < NI; i++)
      if (synced[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES-1)) stable_d[i] = synced[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    HitM = ReadEnM && (ReadAddrM[31:4] == BASE_ADDR[31:4]);
    edge_rd = HitM && (ReadAddrM[3:2] == 2'd2);
    // a rise on the clearing edge survives so the new press is not lost
    btn_edge_d = (edge_rd ? 5'b0 : btn_edge_q) | (stable_d[20:16] & ~stable_q[20:16]);
    sw_changes_d = sw_changes_q + 16'(stable_d[15:0] != stable_q[15:0]);
    ReadDataM = !HitM ? 32'b0 :
                ReadAddrM[3:2] == 2'd0 ? {16'b0, stable_q[15:0]} :
                ReadAddrM[3:2] == 2'd1 ? {27'b0, stable_q[20:16]} :
                ReadAddrM[3:2] == 2'd2 ? {27'b0, btn_edge_q} :
                                         {16'b0, sw_changes_q};
  end
  always_ff @(posedge clk)
    if (rst) begin
      sync_q       <= '0;
      stable_q     <= '0;
      cnt_q        <= '0;
      btn_edge_q   <= '0;
      sw_changes_q <= '0;
    end else begin
      sync_q       <= sync_d;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      btn_edge_q   <= btn_edge_d;
      sw_changes_q <= sw_changes_d;
    end
endmodule

// File: tb/tb_mmio_input_port.sv
// tb_mmio_input_port: directed and randomized checks against a sample-history reference model
module tb_mmio_input_port;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int N = 4;
  localparam int S = 2;
  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] sw = '0;
  logic [4:0]  btn = '0;
  logic        ReadEnM = 0;
  logic [31:0] ReadAddrM = BASE;
  logic [31:0] ReadDataM;
  logic        HitM;
  int errors = 0;
  int checks = 0;
  mmio_input_port #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .ReadEnM(ReadEnM),
    .ReadAddrM(ReadAddrM), .ReadDataM(ReadDataM), .HitM(HitM)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // reference: raw sample history, per-input run of consecutive disagreeing samples
  logic [20:0] hist[$];
  int          run[21];
  logic [20:0] m_stable;
  logic [4:0]  m_edge;
  logic [15:0] m_cnt;
  bit          started = 0;
  always @(posedge clk) begin
    logic [20:0] syn, nxt;
    started = 1;
    if (rst) begin
      hist = {};
      for (int i = 0; i < S; i++) hist.push_back('0);
      foreach (run[i]) run[i] = 0;
      m_stable = '0;
      m_edge = '0;
      m_cnt = '0;
    end else begin
      syn = hist[S-1];
      nxt = m_stable;
      for (int i = 0; i < 21; i++) begin
        if (syn[i] != m_stable[i]) begin
          run[i]++;
          if (run[i] == N) begin
            nxt[i] = syn[i];
            run[i] = 0;
          end
        end else run[i] = 0;
      end
      if (ReadEnM && ReadAddrM[31:4] == BASE[31:4] && ReadAddrM[3:2] == 2'd2) m_edge = '0;
      m_edge |= nxt[20:16] & ~m_stable[20:16];
      if (nxt[15:0] != m_stable[15:0]) m_cnt++;
      m_stable = nxt;
      hist.push_front({btn, sw});
      void'(hist.pop_back());
    end
  end
  function automatic logic exp_hit();
    return ReadEnM && ReadAddrM[31:4] == BASE[31:4];
  endfunction
  function automatic logic [31:0] exp_rd();
    if (!exp_hit()) return '0;
    case (ReadAddrM[3:2])
      2'd0:    return {16'b0, m_stable[15:0]};
      2'd1:    return {27'b0, m_stable[20:16]};
      2'd2:    return {27'b0, m_edge};
      default: return {16'b0, m_cnt};
    endcase
  endfunction
  always @(negedge clk)
    if (started) begin
      chk("model_rd", ReadDataM, exp_rd());
      chk("model_hit", {31'b0, HitM}, {31'b0, exp_hit()});
    end
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rd(logic [31:0] off, logic [31:0] exp, string tag);
    ReadEnM = 1;
    ReadAddrM = BASE + off;
    #1;
    chk(tag, ReadDataM, exp);
  endtask
  initial begin
    int idx;
    sw = 16'hFFFF;
    btn = 5'h1F;
    ReadEnM = 1;
    step(3);
    chk("rst_rd", ReadDataM, 32'h0);
    chk("rst_hit", {31'b0, HitM}, 32'h1);
    rst = 0;
    step(5);
    rd(0, 32'h0, "sw_early");
    step(1);
    rd(0, 32'h0000_FFFF, "sw_after_rst");
    rd(4'hC, 32'h1, "swcnt_after_rst");
    rd(4'h8, 32'h1F, "edge_after_rst");
    step(1);
    ReadAddrM = BASE;
    sw = '0;
    btn = '0;
    step(10);
    rd(4'hC, 32'h2, "swcnt_release");
    ReadAddrM = BASE;
    sw = 16'h0008;
    step(3);
    sw = '0;
    step(10);
    rd(0, 32'h0, "glitch_sw");
    rd(4'hC, 32'h2, "glitch_cnt");
    ReadAddrM = BASE;
    sw = 16'h0008;
    step(5);
    rd(0, 32'h0, "accept_early");
    step(1);
    rd(0, 32'h8, "accept_sw");
    rd(4'hC, 32'h3, "accept_cnt");
    ReadAddrM = BASE;
    btn = 5'h01;
    step(8);
    rd(4'h8, 32'h1, "edge_first");
    step(1);
    rd(4'h8, 32'h0, "edge_cleared");
    ReadAddrM = BASE;
    btn = 5'h05;
    step(5);
    rd(4'h8, 32'h0, "setclr_read");
    step(1);
    rd(4'h8, 32'h4, "setclr_kept");
    step(1);
    rd(4'h8, 32'h0, "setclr_gone");
    rd(5'h10, 32'h0, "outside_rd");
    chk("outside_hit", {31'b0, HitM}, 32'h0);
    rd(4'h7, 32'h5, "btn_unaligned");
    ReadEnM = 0;
    ReadAddrM = BASE + 8;
    btn = 5'h15;
    step(8);
    chk("noen_hit", {31'b0, HitM}, 32'h0);
    chk("noen_rd", ReadDataM, 32'h0);
    rd(4'h8, 32'h10, "noen_kept");
    step(1);
    ReadAddrM = BASE + 12;
    force dut.sw_changes_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    step(1);
    release dut.sw_changes_q;
    rd(4'hC, 32'hFFFF, "wrap_pre");
    sw = '0;
    step(6);
    rd(4'hC, 32'h0, "wrap_post");
    for (int c = 0; c < 400; c++) begin
      step(1);
      rst = (c == 200);
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 15);
        sw[idx] = ~sw[idx];
      end
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, 4);
        btn[idx] = ~btn[idx];
      end
      ReadEnM = 1'($urandom_range(0, 1));
      ReadAddrM = ($urandom_range(0, 5) == 0) ? $urandom : BASE + $urandom_range(0, 31);
    end
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
